mips_multicycle_control: RTL and testbench

Multicycle sequencer for the MIPS datapath. One shared memory port serves both instruction fetch and data access, and one ALU serves both PC arithmetic and execution. The block decodes the opcode and funct fields from the instruction register and steps through per-instruction states, driving every datapath select and write strobe. It sits beside the register file, ALU, ALU-control and memory blocks in the processor top level, in place of the single-cycle control unit. A `MemReady` handshake stretches the memory states.

---
 rtl/mips_multicycle_control.sv | 148 ++++++++++++++
 tb/tb_mips_multicycle_control.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a shared memory port and ALU.
// Optional JAL support is built when MC_CTRL_JAL_EN is defined; otherwise opcode 0x03 is illegal.
`timescale 1ns/1ps

module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
`ifdef MC_CTRL_JAL_EN
    IWB    = 4'd11,
    JR     = 4'd12,
    JAL    = 4'd13
`else
    IWB    = 4'd11,
    JR     = 4'd12
`endif
  } stateT;

  stateT state, nextState;
  logic  isStore;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // MEMADR must not look at the opcode, so remember lw-vs-sw while decoding.
  always_ff @(posedge clk) begin
    if (reset)                isStore <= 1'b0;
    else if (state == DECODE) isStore <= (Opcode == OP_SW);
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:  if (MemReady) nextState = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:    nextState = MEMADR;
          OP_RTYPE:        nextState = (Funct == FN_JR) ? JR : EXEC;
          OP_BEQ, OP_BNE:  nextState = BRANCH;
          OP_ADDI, OP_ORI: nextState = IEXEC;
          OP_J:            nextState = JUMP;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:          nextState = JAL;
`endif
          default:         nextState = FETCH;
        endcase
      end
      MEMADR: nextState = isStore ? MEMWR : MEMRD;
      MEMRD:  if (MemReady) nextState = MEMWB;
      MEMWR:  if (MemReady) nextState = FETCH;
      EXEC:   nextState = RWB;
      IEXEC:  nextState = IWB;
      default: nextState = FETCH;
    endcase
  end

  // An illegal opcode is exactly the DECODE case that falls back to FETCH.
  always_comb begin
    PCEn = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    IRWrite = 1'b0; RegWrite = 1'b0; RegDst = 2'b00; MemtoReg = 2'b00;
    ALUSrcA = 1'b0; ALUSrcB = 2'b00; ALUOp = 2'b00; PCSource = 2'b00;
    InstrDone = 1'b0; IllegalOp = 1'b0; State = 4'd0;
    if (!reset) begin
      State = state;
      case (state)
        FETCH: begin
          MemRead = 1'b1; ALUSrcB = 2'b01;
          IRWrite = MemReady; PCEn = MemReady;
        end
        DECODE: begin
          ALUSrcB   = 2'b11;
          IllegalOp = (nextState == FETCH);
          InstrDone = (nextState == FETCH);
        end
        MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
        MEMWB:  begin RegWrite = 1'b1; MemtoReg = 2'b01; InstrDone = 1'b1; end
        MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; InstrDone = MemReady; end
        EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
        RWB:    begin RegWrite = 1'b1; RegDst = 2'b01; InstrDone = 1'b1; end
        BRANCH: begin
          ALUSrcA = 1'b1; ALUOp = 2'b01; PCSource = 2'b01; InstrDone = 1'b1;
          PCEn = (Opcode == OP_BEQ) ? Zero : ~Zero;
        end
        IEXEC:  begin
          ALUSrcA = 1'b1; ALUSrcB = 2'b10;
          ALUOp = (Opcode == OP_ORI) ? 2'b11 : 2'b00;
        end
        IWB:    begin RegWrite = 1'b1; InstrDone = 1'b1; end
        JUMP:   begin PCSource = 2'b10; PCEn = 1'b1; InstrDone = 1'b1; end
        JR:     begin PCSource = 2'b11; PCEn = 1'b1; InstrDone = 1'b1; end
`ifdef MC_CTRL_JAL_EN
        JAL:    begin
          PCSource = 2'b10; PCEn = 1'b1; RegWrite = 1'b1;
          RegDst = 2'b10; MemtoReg = 2'b10; InstrDone = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench for mips_multicycle_control: an instruction-level model
// expands each instruction into its expected per-cycle outputs and cycle count.
`timescale 1ns/1ps

module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       Zero, MemReady;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
  logic       ALUSrcA, InstrDone, IllegalOp;
  logic [3:0] State;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .InstrDone(InstrDone), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcEn, iorD, memRead, memWrite, irWrite, regWrite;
    logic [1:0] regDst, memtoReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic       instrDone, illegalOp;
  } obsT;

  obsT  expQ[$];
  logic mrQ[$];
  logic fetchQ[$];
  int   checks = 0;
  int   failures = 0;

  function automatic obsT observed();
    obsT o;
    o.st = State; o.pcEn = PCEn; o.iorD = IorD; o.memRead = MemRead;
    o.memWrite = MemWrite; o.irWrite = IRWrite; o.regWrite = RegWrite;
    o.regDst = RegDst; o.memtoReg = MemtoReg; o.aluSrcA = ALUSrcA;
    o.aluSrcB = ALUSrcB; o.aluOp = ALUOp; o.pcSource = PCSource;
    o.instrDone = InstrDone; o.illegalOp = IllegalOp;
    return o;
  endfunction

  function automatic bit jalEnabled();
`ifdef MC_CTRL_JAL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B: return 1'b1;
      6'h03:   return jalEnabled();
      default: return 1'b0;
    endcase
  endfunction

  // Instruction latency with MemReady always high, plus every wait cycle.
  function automatic int cyclesFor(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    int base;
    case (op)
      6'h23:          base = 5;
      6'h2B:          base = 4;
      6'h00:          base = (fn == 6'h08) ? 3 : 4;
      6'h08, 6'h0D:   base = 4;
      6'h04, 6'h05, 6'h02: base = 3;
      6'h03:          base = jalEnabled() ? 3 : 2;
      default:        base = 2;
    endcase
    return base + fw + ((op == 6'h23 || op == 6'h2B) ? mw : 0);
  endfunction

  task automatic push(input obsT o, input logic mr, input logic isFetch);
    expQ.push_back(o); mrQ.push_back(mr); fetchQ.push_back(isFetch);
  endtask

  task automatic buildInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw);
    obsT o;
    expQ.delete(); mrQ.delete(); fetchQ.delete();
    for (int i = 0; i <= fw; i++) begin
      o = '0; o.memRead = 1'b1; o.aluSrcB = 2'b01;
      o.irWrite = (i == fw); o.pcEn = (i == fw);
      push(o, (i == fw), 1'b1);
    end
    o = '0; o.st = 4'd1; o.aluSrcB = 2'b11;
    if (!legal(op)) begin
      o.instrDone = 1'b1; o.illegalOp = 1'b1;
      push(o, 1'($urandom), 1'b0);
    end else begin
      push(o, 1'($urandom), 1'b0);
      if (op == 6'h23 || op == 6'h2B) begin
        o = '0; o.st = 4'd2; o.aluSrcA = 1'b1; o.aluSrcB = 2'b10;
        push(o, 1'($urandom), 1'b0);
        for (int i = 0; i <= mw; i++) begin
          o = '0; o.iorD = 1'b1;
          if (op == 6'h23) begin o.st = 4'd3; o.memRead = 1'b1; end
          else begin o.st = 4'd5; o.memWrite = 1'b1; o.instrDone = (i == mw); end
          push(o, (i == mw), 1'b0);
        end
        if (op == 6'h23) begin
          o = '0; o.st = 4'd4; o.regWrite = 1'b1; o.memtoReg = 2'b01; o.instrDone = 1'b1;
          push(o, 1'($urandom), 1'b0);
        end
      end else if (op == 6'h00 && fn == 6'h08) begin
        o = '0; o.st = 4'd12; o.pcSource = 2'b11; o.pcEn = 1'b1; o.instrDone = 1'b1;
        push(o, 1'($urandom), 1'b0);
      end else if (op == 6'h00) begin
        o = '0; o.st = 4'd6; o.aluSrcA = 1'b1; o.aluOp = 2'b10;
        push(o, 1'($urandom), 1'b0);
        o = '0; o.st = 4'd7; o.regWrite = 1'b1; o.regDst = 2'b01; o.instrDone = 1'b1;
        push(o, 1'($urandom), 1'b0);
      end else if (op == 6'h04 || op == 6'h05) begin
        o = '0; o.st = 4'd8; o.aluSrcA = 1'b1; o.aluOp = 2'b01; o.pcSource = 2'b01;
        o.instrDone = 1'b1; o.pcEn = (op == 6'h04) ? z : !z;
        push(o, 1'($urandom), 1'b0);
      end else if (op == 6'h08 || op == 6'h0D) begin
        o = '0; o.st = 4'd10; o.aluSrcA = 1'b1; o.aluSrcB = 2'b10;
        o.aluOp = (op == 6'h0D) ? 2'b11 : 2'b00;
        push(o, 1'($urandom), 1'b0);
        o = '0; o.st = 4'd11; o.regWrite = 1'b1; o.instrDone = 1'b1;
        push(o, 1'($urandom), 1'b0);
      end else if (op == 6'h02) begin
        o = '0; o.st = 4'd9; o.pcSource = 2'b10; o.pcEn = 1'b1; o.instrDone = 1'b1;
        push(o, 1'($urandom), 1'b0);
      end else begin
        o = '0; o.st = 4'd13; o.pcSource = 2'b10; o.pcEn = 1'b1; o.regWrite = 1'b1;
        o.regDst = 2'b10; o.memtoReg = 2'b10; o.instrDone = 1'b1;
        push(o, 1'($urandom), 1'b0);
      end
    end
  endtask

  // Entered and left at a falling edge; reset is held for exactly one rising edge.
  task automatic doReset(input string name);
    reset = 1'b1; MemReady = 1'($urandom); Opcode = 6'($urandom); Zero = 1'($urandom);
    #2;
    checks++;
    if (observed() !== obsT'('0)) begin
      failures++;
      $display("[TB] FAIL %s reset outputs: got %h expected %h", name, observed(), obsT'('0));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic runInstr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int fw, input int mw, input int stopAt);
    int n, doneAt, pulses, want;
    bit bad;
    doneAt = 0; pulses = 0; bad = 1'b0;
    buildInstr(op, fn, z, fw, mw);
    n = expQ.size();
    if (stopAt >= 0 && stopAt < n) n = stopAt;
    for (int i = 0; i < n && !bad; i++) begin
      MemReady = mrQ[i];
      Opcode   = fetchQ[i] ? 6'($urandom) : op;
      Funct    = fetchQ[i] ? 6'($urandom) : fn;
      Zero     = z;
      #2;
      checks++;
      if (observed() !== expQ[i]) begin
        failures++; bad = 1'b1;
        $display("[TB] FAIL %s cycle %0d op=%h: got %h expected %h", name, i, op, observed(), expQ[i]);
      end
      if (InstrDone === 1'b1) begin
        pulses++;
        if (doneAt == 0) doneAt = i + 1;
      end
      @(negedge clk);
    end
    if (bad) doReset(name);
    else if (stopAt < 0) begin
      want = cyclesFor(op, fn, fw, mw);
      checks++;
      if (doneAt != want || pulses != 1) begin
        failures++;
        $display("[TB] FAIL %s latency op=%h: done at cycle %0d with %0d pulses, expected cycle %0d with 1 pulse",
                 name, op, doneAt, pulses, want);
      end
    end
  endtask

  task automatic test_reset();
    doReset("reset");
    runInstr("post_reset_j", 6'h02, 6'h00, 1'b0, 0, 0, -1);
  endtask

  task automatic test_lw();
    runInstr("lw", 6'h23, 6'h00, 1'b0, 0, 0, -1);
    runInstr("lw_waits", 6'h23, 6'h00, 1'b1, 2, 2, -1);
  endtask

  task automatic test_sw_wait();
    runInstr("sw_wait3", 6'h2B, 6'h00, 1'b0, 0, 3, -1);
    runInstr("sw", 6'h2B, 6'h00, 1'b0, 0, 0, -1);
  endtask

  task automatic test_branch();
    runInstr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0, -1);
    runInstr("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0, -1);
    runInstr("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0, -1);
    runInstr("bne_z0", 6'h05, 6'h00, 1'b0, 1, 0, -1);
  endtask

  task automatic test_rtype();
    runInstr("jr", 6'h00, 6'h08, 1'b0, 0, 0, -1);
    runInstr("add", 6'h00, 6'h20, 1'b0, 0, 0, -1);
    runInstr("addi", 6'h08, 6'h00, 1'b0, 0, 0, -1);
    runInstr("ori", 6'h0D, 6'h00, 1'b0, 0, 0, -1);
  endtask

  task automatic test_jal_and_illegal();
    runInstr("op03", 6'h03, 6'h00, 1'b0, 0, 0, -1);
    runInstr("illegal", 6'h3F, 6'h00, 1'b0, 0, 0, -1);
  endtask

  task automatic test_reset_mid_memrd();
    runInstr("lw_abandon", 6'h23, 6'h00, 1'b0, 0, 5, 4);
    doReset("reset_mid_memrd");
    runInstr("after_mid_reset", 6'h00, 6'h20, 1'b0, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [10];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h03, 6'h00};
    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      fn = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom);
      runInstr("random", op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    reset = 1'b1; Opcode = 6'h00; Funct = 6'h00; Zero = 1'b0; MemReady = 1'b0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch();
    test_rtype();
    test_jal_and_illegal();
    test_reset_mid_memrd();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
